// File: rtl/convfpga_pkg.sv
// Shared constants and the broadcaster FSM state encoding for the conv datapath.
package convfpga_pkg;

    localparam int COORD_W    = 8;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_ADDR_W = 16;

    typedef logic [COORD_W-1:0] coord_t;

    typedef enum logic [2:0] {
        IDLE,
        ADV,
        WAIT_LOW,
        WAIT_RND,
        SCAN,
        DRAIN,
        FIN
    } bcast_state_t;

endpackage

// File: rtl/pixel_broadcaster_if.sv
// Positioner handshake, image memory read port and pixel broadcast bus of the broadcaster.
interface pixel_broadcaster_if
    import convfpga_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
);

    logic              start;
    coord_t            image_dim;
    logic [1:0]        padding;
    coord_t            x_min;
    coord_t            x_max;
    coord_t            y_min;
    coord_t            y_max;
    logic              round;
    logic              done;
    logic              advance;
    logic              mem_rd;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              pix_valid;
    coord_t            pix_x;
    coord_t            pix_y;
    logic [DATA_W-1:0] pix_data;
    logic              layer_done;
    logic              busy;

    modport master (
        input  start, image_dim, padding, x_min, x_max, y_min, y_max,
        input  round, done, mem_data,
        output advance, mem_rd, mem_addr, pix_valid, pix_x, pix_y, pix_data,
        output layer_done, busy
    );

    modport slave (
        output start, image_dim, padding, x_min, x_max, y_min, y_max,
        output round, done, mem_data,
        input  advance, mem_rd, mem_addr, pix_valid, pix_x, pix_y, pix_data,
        input  layer_done, busy
    );

endinterface

// File: rtl/broadcast_addr_gen.sv
// Raster pointer over a latched box, padding test and linear address; combinational outputs.
// BROADCAST_SKIP_PADDING_EN clips the box to the real image so padding is never visited.
module broadcast_addr_gen
    import convfpga_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic              i_step,
    input  coord_t            i_x_min,
    input  coord_t            i_x_max,
    input  coord_t            i_y_min,
    input  coord_t            i_y_max,
    input  coord_t            i_image_dim,
    input  logic [1:0]        i_padding,
    output coord_t            o_x,
    output coord_t            o_y,
    output logic              o_is_pad,
    output logic              o_last,
    output logic              o_empty,
    output logic [ADDR_W-1:0] o_addr
);

    coord_t     r_x, r_y, r_x_lo, r_x_hi, r_y_hi, r_dim;
    logic [1:0] r_pad;
    logic       r_empty;

    logic [COORD_W:0] w_ld_edge;
    coord_t           w_lo_x, w_hi_x, w_lo_y, w_hi_y;
    logic             w_ld_empty;
    logic [COORD_W:0] w_edge;
    logic [ADDR_W-1:0] w_row, w_col;

    assign w_ld_edge = (COORD_W+1)'(i_image_dim) + (COORD_W+1)'(i_padding);

`ifdef BROADCAST_SKIP_PADDING_EN
    // First real row/column is at padding, last at image_dim+padding-1.
    assign w_lo_x = (i_x_min < coord_t'(i_padding)) ? coord_t'(i_padding) : i_x_min;
    assign w_lo_y = (i_y_min < coord_t'(i_padding)) ? coord_t'(i_padding) : i_y_min;
    assign w_hi_x = ((COORD_W+1)'(i_x_max) >= w_ld_edge) ? coord_t'(w_ld_edge - 1'b1) : i_x_max;
    assign w_hi_y = ((COORD_W+1)'(i_y_max) >= w_ld_edge) ? coord_t'(w_ld_edge - 1'b1) : i_y_max;
    assign w_ld_empty = (w_lo_x > w_hi_x) || (w_lo_y > w_hi_y) || (i_image_dim == '0);
`else
    assign w_lo_x = i_x_min;
    assign w_lo_y = i_y_min;
    assign w_hi_x = i_x_max;
    assign w_hi_y = i_y_max;
    assign w_ld_empty = (w_lo_x > w_hi_x) || (w_lo_y > w_hi_y) || (w_ld_edge != w_ld_edge);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x     <= '0;
            r_y     <= '0;
            r_x_lo  <= '0;
            r_x_hi  <= '0;
            r_y_hi  <= '0;
            r_dim   <= '0;
            r_pad   <= '0;
            r_empty <= 1'b0;
        end else if (i_load) begin
            r_x     <= w_lo_x;
            r_y     <= w_lo_y;
            r_x_lo  <= w_lo_x;
            r_x_hi  <= w_hi_x;
            r_y_hi  <= w_hi_y;
            r_dim   <= i_image_dim;
            r_pad   <= i_padding;
            r_empty <= w_ld_empty;
        end else if (i_step) begin
            if (r_x == r_x_hi) begin
                r_x <= r_x_lo;
                r_y <= r_y + 8'd1;
            end else begin
                r_x <= r_x + 8'd1;
            end
        end
    end

    assign w_edge   = (COORD_W+1)'(r_dim) + (COORD_W+1)'(r_pad);
    assign o_is_pad = (r_x < coord_t'(r_pad)) || ((COORD_W+1)'(r_x) >= w_edge) ||
                      (r_y < coord_t'(r_pad)) || ((COORD_W+1)'(r_y) >= w_edge);

    // Only meaningful for real pixels, where both subtractions are non-negative.
    assign w_row  = ADDR_W'(r_y - coord_t'(r_pad));
    assign w_col  = ADDR_W'(r_x - coord_t'(r_pad));
    assign o_addr = w_row * ADDR_W'(r_dim) + w_col;

    assign o_x     = r_x;
    assign o_y     = r_y;
    assign o_last  = (r_x == r_x_hi) && (r_y == r_y_hi);
    assign o_empty = r_empty;

endmodule

// File: rtl/pixel_broadcaster.sv
// Walks each positioner round's box and broadcasts one pixel per visited coordinate, 1 cycle later.
// No backpressure: memory has fixed 1-cycle latency. Optional macro: BROADCAST_SKIP_PADDING_EN.
module pixel_broadcaster
    import convfpga_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input logic                 clk,
    input logic                 rst,
    pixel_broadcaster_if.master bus
);

    bcast_state_t r_state, w_next;

    logic              w_advance, w_load, w_step, w_visit, w_mem_rd;
    coord_t            w_x, w_y;
    logic              w_is_pad, w_last, w_empty;
    logic [ADDR_W-1:0] w_addr;

    logic   r_vld_d, r_pad_d;
    coord_t r_x_d, r_y_d;

    broadcast_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_step      (w_step),
        .i_x_min     (bus.x_min),
        .i_x_max     (bus.x_max),
        .i_y_min     (bus.y_min),
        .i_y_max     (bus.y_max),
        .i_image_dim (bus.image_dim),
        .i_padding   (bus.padding),
        .o_x         (w_x),
        .o_y         (w_y),
        .o_is_pad    (w_is_pad),
        .o_last      (w_last),
        .o_empty     (w_empty),
        .o_addr      (w_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        w_advance = 1'b0;
        w_load    = 1'b0;
        w_step    = 1'b0;
        w_visit   = 1'b0;
        unique case (r_state)
            IDLE:     if (bus.start) w_next = ADV;
            ADV: begin
                w_advance = 1'b1;
                w_next    = WAIT_LOW;
            end
            // A round flag still high from the previous round must drop first.
            WAIT_LOW: if (!bus.round) w_next = WAIT_RND;
            WAIT_RND: if (bus.round) begin
                w_load = 1'b1;
                w_next = SCAN;
            end
            SCAN: begin
                if (w_empty) begin
                    w_next = DRAIN;
                end else begin
                    w_visit = 1'b1;
                    if (w_last) w_next = DRAIN;
                    else        w_step = 1'b1;
                end
            end
            DRAIN:    w_next = bus.done ? FIN : ADV;
            FIN:      if (bus.start) w_next = ADV;
            default:  w_next = IDLE;
        endcase
    end

    assign w_mem_rd = w_visit && !w_is_pad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_d <= 1'b0;
            r_pad_d <= 1'b0;
            r_x_d   <= '0;
            r_y_d   <= '0;
        end else begin
            r_vld_d <= w_visit;
            r_pad_d <= w_visit && w_is_pad;
            r_x_d   <= w_visit ? w_x : '0;
            r_y_d   <= w_visit ? w_y : '0;
        end
    end

    assign bus.advance    = w_advance;
    assign bus.mem_rd     = w_mem_rd;
    assign bus.mem_addr   = w_mem_rd ? w_addr : '0;
    assign bus.pix_valid  = r_vld_d;
    assign bus.pix_x      = r_x_d;
    assign bus.pix_y      = r_y_d;
    assign bus.pix_data   = (r_vld_d && !r_pad_d) ? bus.mem_data : DATA_W'(0);
    assign bus.layer_done = (r_state == FIN);
    assign bus.busy       = (r_state != IDLE) && (r_state != FIN);

endmodule

// File: tb/tb_pixel_broadcaster.sv
// Directed bench for pixel_broadcaster: memory model returns 0xA000+addr one cycle after mem_rd.
module tb_pixel_broadcaster;
    import convfpga_pkg::*;

    logic clk;
    logic rst;

    pixel_broadcaster_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    pixel_broadcaster #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int n_checks = 0;
    int n_errors = 0;

    int bx[$];
    int by[$];
    int bd[$];
    int adv_cnt = 0;
    int rd_cnt  = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (bus.mem_rd) bus.mem_data <= 16'hA000 + bus.mem_addr;
        else            bus.mem_data <= 16'hDEAD;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.pix_valid) begin
                bx.push_back(int'(bus.pix_x));
                by.push_back(int'(bus.pix_y));
                bd.push_back(int'(bus.pix_data));
            end
            if (bus.advance) adv_cnt++;
            if (bus.mem_rd)  rd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic set_box(input int xa, input int xb, input int ya, input int yb);
        bus.x_min = 8'(xa);
        bus.x_max = 8'(xb);
        bus.y_min = 8'(ya);
        bus.y_max = 8'(yb);
    endtask

    task automatic wait_layer_done(input int budget);
        for (int i = 0; i < budget && !bus.layer_done; i++) @(negedge clk);
    endtask

    function automatic int find_beat(input int b0, input int x, input int y);
        for (int i = b0; i < bx.size(); i++)
            if (bx[i] == x && by[i] == y) return bd[i];
        return -1;
    endfunction

    initial begin
        int b0, a0, r0, n, err, ex, exp_beats, exp00, i_exit, i_drain;
        bit pad;
        rst = 1'b1;
        bus.start = 1'b0;  bus.round = 1'b0;  bus.done = 1'b0;
        bus.image_dim = 8'd4;  bus.padding = 2'd1;
        set_box(0, 5, 0, 5);

        // Reset state
        wait_cyc(2);
        check("rst_advance", bus.advance, 0);
        check("rst_mem_rd", bus.mem_rd, 0);
        check("rst_pix_valid", bus.pix_valid, 0);
        check("rst_layer_done", bus.layer_done, 0);
        check("rst_busy", bus.busy, 0);
        rst = 1'b0;
        wait_cyc(2);

        // Single full layer, 6x6 padded box over a 4x4 image
        bus.done = 1'b1;
        b0 = bx.size();  a0 = adv_cnt;
        pulse_start();
        check("adv_at_start_plus1", bus.advance, 1);
        wait_cyc(1);
        check("adv_one_cycle", bus.advance, 0);
        wait_cyc(4);
        check("no_beat_before_round", bx.size() - b0, 0);
        check("busy_waiting", bus.busy, 1);
        bus.round = 1'b1;
        wait_layer_done(200);
        check("layer_done_full", bus.layer_done, 1);
        wait_cyc(3);
`ifdef BROADCAST_SKIP_PADDING_EN
        exp_beats = 16;  exp00 = -1;
`else
        exp_beats = 36;  exp00 = 0;
`endif
        check("beat_count_full", bx.size() - b0, exp_beats);
        check("beat_0_0", find_beat(b0, 0, 0), exp00);
        check("beat_1_1", find_beat(b0, 1, 1), 32'hA000);
        check("beat_4_4", find_beat(b0, 4, 4), 32'hA00F);
        n = 0;  err = 0;
        for (int y = 0; y < 6; y++) begin
            for (int x = 0; x < 6; x++) begin
                pad = (x < 1) || (x >= 5) || (y < 1) || (y >= 5);
`ifdef BROADCAST_SKIP_PADDING_EN
                if (pad) continue;
`endif
                ex = pad ? 0 : 'hA000 + (y - 1) * 4 + (x - 1);
                if (b0 + n >= bx.size()) err++;
                else if (bx[b0+n] != x || by[b0+n] != y || bd[b0+n] != ex) err++;
                n++;
            end
        end
        check("raster_order", err, 0);
        check("no_adv_after_last", adv_cnt - a0, 1);
        check("busy_fin", bus.busy, 0);

        // Two rounds; round left high from before must be masked
        bus.done = 1'b0;
        set_box(1, 2, 1, 1);
        b0 = bx.size();  a0 = adv_cnt;
        pulse_start();
        check("start_clears_layer_done", bus.layer_done, 0);
        wait_cyc(3);
        pulse_start();
        wait_cyc(3);
        check("stale_round_masked", bx.size() - b0, 0);
        check("start_ignored_busy", adv_cnt - a0, 1);
        bus.round = 1'b0;
        wait_cyc(2);
        bus.round = 1'b1;
        wait_cyc(12);
        check("round1_beats", bx.size() - b0, 2);
        check("one_adv_between", adv_cnt - a0, 2);
        wait_cyc(10);
        check("held_round_no_rebcast", bx.size() - b0, 2);
        check("held_round_state", 32'(dut.r_state), 32'(WAIT_LOW));
        bus.done = 1'b1;
        set_box(2, 3, 2, 2);
        bus.round = 1'b0;
        wait_cyc(2);
        bus.round = 1'b1;
        wait_layer_done(50);
        check("layer_done_2rnd", bus.layer_done, 1);
        wait_cyc(2);
        check("beats_2rnd", bx.size() - b0, 4);
        check("adv_2rnd", adv_cnt - a0, 2);
        if (bx.size() - b0 == 4) begin
            check("r1_b0", bd[b0],   32'hA000);
            check("r1_b1", bd[b0+1], 32'hA001);
            check("r2_b0", bd[b0+2], 32'hA005);
            check("r2_b1", bd[b0+3], 32'hA006);
        end

        // Reset on the 5th SCAN beat
        set_box(1, 4, 1, 4);
        pulse_start();
        bus.round = 1'b0;
        wait_cyc(2);
        bus.round = 1'b1;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (dut.r_state == SCAN) n++;
            if (n == 5) break;
        end
        check("scan5_reached", n, 5);
        check("pre_rst_mem_rd", bus.mem_rd, 1);
        check("pre_rst_pix_valid", bus.pix_valid, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_advance", bus.advance, 0);
        check("mid_rst_mem_rd", bus.mem_rd, 0);
        check("mid_rst_mem_addr", bus.mem_addr, 0);
        check("mid_rst_pix_valid", bus.pix_valid, 0);
        check("mid_rst_pix_xy", {bus.pix_x, bus.pix_y}, 0);
        check("mid_rst_pix_data", bus.pix_data, 0);
        check("mid_rst_layer_done", bus.layer_done, 0);
        check("mid_rst_busy", bus.busy, 0);
        b0 = bx.size();  a0 = adv_cnt;
        wait_cyc(2);
        rst = 1'b0;
        wait_cyc(4);
        check("post_rst_idle", 32'(dut.r_state), 32'(IDLE));
        check("post_rst_no_beats", bx.size() - b0, 0);
        check("post_rst_no_adv", adv_cnt - a0, 0);

        // Degenerate box
        bus.round = 1'b0;
        set_box(3, 2, 0, 5);
        b0 = bx.size();  r0 = rd_cnt;
        pulse_start();
        wait_cyc(2);
        check("degen_wait_rnd", 32'(dut.r_state), 32'(WAIT_RND));
        bus.round = 1'b1;
        i_exit = -1;  i_drain = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i_exit < 0 && dut.r_state != WAIT_RND) i_exit = i;
            if (i_drain < 0 && dut.r_state == DRAIN) i_drain = i;
        end
        check("degen_drain_timing", i_drain - i_exit, 1);
        check("degen_no_beats", bx.size() - b0, 0);
        check("degen_no_mem_rd", rd_cnt - r0, 0);
        check("degen_layer_done", bus.layer_done, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/pixel_broadcaster.md
PIXEL_BROADCASTER -- requirements
Module: pixel_broadcaster

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, pixel width; ADDR_W, default 16, image memory address width.
REQ-002 Port clk, input, 1, sole clock; all flops on rising edge.
REQ-003 Port rst, input, 1, reset, asynchronous and active-high.
REQ-004 Port start, input, 1, one-cycle pulse that begins a layer.
REQ-005 Port image_dim, input, 8, unpadded image side length.
REQ-006 Port padding, input, 2, filter half-size.
REQ-007 Ports x_min, x_max, y_min, y_max, input, 8 each, positioner round bounding box in padded coordinates.
REQ-008 Port round, input, 1, positioner round-placed flag.
REQ-009 Port done, input, 1, positioner last-pixel-placed flag.
REQ-010 Port advance, output, 1, one-cycle pulse requesting the next positioner round.
REQ-011 Ports mem_rd, output, 1, read strobe; mem_addr, output, ADDR_W, address; mem_data, input, DATA_W, read data valid exactly 1 cycle after mem_rd.
REQ-012 Ports pix_valid, output, 1; pix_x, pix_y, output, 8 each; pix_data, output, DATA_W; these form the pixel broadcast to all allocators.
REQ-013 Ports layer_done, output, 1, level, set after the final round is broadcast; busy, output, 1, high when the FSM is not in IDLE or FIN.

Function
REQ-014 FSM states SHALL be IDLE, ADV, WAIT_LOW, WAIT_RND, SCAN, DRAIN, FIN.
REQ-015 IDLE: start SHALL go to ADV; all other inputs are ignored.
REQ-016 ADV SHALL last exactly 1 cycle with advance=1, then go to WAIT_LOW.
REQ-017 WAIT_LOW SHALL hold until round==0, then go to WAIT_RND; this masks a stale round from the previous round.
REQ-018 WAIT_RND SHALL hold until round==1, then latch x_min, x_max, y_min, y_max, set the scan pointer to (x_min,y_min), and go to SCAN.
REQ-019 SCAN SHALL visit one padded coordinate per cycle in raster order: x runs from x_min to x_max, then wraps to x_min with y+1; y ends at y_max.
REQ-020 When x<padding, x>=image_dim+padding, y<padding, or y>=image_dim+padding, the coordinate is padding: mem_rd=0, and the pixel is emitted with data 0.
REQ-021 Otherwise, mem_rd=1 and mem_addr=(y-padding)*image_dim+(x-padding), computed at ADDR_W bits with no truncation for image_dim<=255.
REQ-022 Each visited coordinate SHALL produce pix_valid=1 exactly 1 cycle later, with pix_x and pix_y equal to the visited coordinate; pix_data is mem_data for a real pixel and 0 for padding.
REQ-023 After the (x_max,y_max) visit, go to DRAIN for 1 cycle to flush the final beat.
REQ-024 From DRAIN: if done==1, go to FIN; else go to ADV.
REQ-025 FIN SHALL set layer_done=1 and hold it until rst or start; start in FIN clears layer_done and goes to ADV.
REQ-026 A degenerate box (x_min>x_max or y_min>y_max) SHALL emit zero beats and go directly to DRAIN.
REQ-027 start outside IDLE/FIN SHALL be ignored.

Reset
REQ-028 Asserting rst at any time, including mid-SCAN, SHALL force IDLE, advance=0, mem_rd=0, mem_addr=0, pix_valid=0, pix_x=0, pix_y=0, pix_data=0, layer_done=0, busy=0, and discard any in-flight beat.

Configuration
REQ-029 With BROADCAST_SKIP_PADDING_EN defined, padding coordinates SHALL be skipped with no cycle spent and no beat emitted; allocators treat absent pixels as zero.
REQ-030 Without BROADCAST_SKIP_PADDING_EN, padding beats SHALL be emitted as specified in REQ-020 and REQ-022.

Structure
REQ-031 The shared package convfpga_pkg SHALL hold COORD_W=8, the default DATA_W/ADDR_W, and the FSM state enum.
REQ-032 Raster stepping, the padding test, and address multiply SHALL live in sub-module broadcast_addr_gen; the FSM and output pipeline register stay in pixel_broadcaster.

Verification
REQ-033 Reset then start: advance SHALL pulse for 1 cycle at start+1; no pix_valid before round rises.
REQ-034 image_dim=4, padding=1, box 0..5 x 0..5, done=1: 36 beats; beat (0,0) data 0; beat (1,1) from addr 0; beat (4,4) from addr 15; then layer_done=1 and no advance.
REQ-035 Same stimulus with BROADCAST_SKIP_PADDING_EN defined: exactly 16 beats, (1,1)..(4,4), addr 0..15 in order.
REQ-036 Two rounds (done=0, then done=1): exactly one advance between rounds; round held at 1 through ADV is not re-broadcast until round drops and rises again.
REQ-037 rst asserted on the 5th SCAN beat: all outputs SHALL be 0 in the same cycle, and the FSM SHALL be in IDLE after rst releases.
REQ-038 Box x_min=3, x_max=2: no beats; DRAIN is reached 1 cycle after WAIT_RND exits.
